// File: rtl/scope_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  scope_fb_arbiter_if
//  Request/grant bus between scan-out reader, acquisition writer and memory.
//  Rev 1.0
// ============================================================================
interface scope_fb_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8
);
   logic              vblank;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_gnt;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_gnt;
   logic              wr_forced;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // master: the arbiter; slave: requesters and memory macro seen together
   modport master (
      input  vblank, rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
      output rd_gnt, rd_valid, rd_data, wr_gnt, wr_forced,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output vblank, rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
      input  rd_gnt, rd_valid, rd_data, wr_gnt, wr_forced,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/scope_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  scope_fb_arbiter
//  Single-port frame memory arbiter: reader priority in active video, writer
//  priority in vblank, with a starvation guard forcing a write slot.
//  Rev 1.0
// ============================================================================
module scope_fb_arbiter #(
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 16
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   scope_fb_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      RD_PRI = 2'd0,
      WR_PRI = 2'd1,
      FORCE  = 2'd2
   } state_t;

   localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

   state_t            r_state;
   logic [7:0]        r_waitCnt;
   logic [7:0]        w_waitNext;
   logic              w_rdGnt;
   logic              w_wrGnt;
   logic              r_rdPend;
   logic              r_rdValid;
   logic              r_memEn;
   logic              r_memWe;
   logic [ADDR_W-1:0] r_memAddr;
   logic [DATA_W-1:0] r_memWdata;

   // Grants are held low while reset is asserted so requesters never see one.
   always_comb begin
      w_rdGnt = 1'b0;
      w_wrGnt = 1'b0;
      if (rst_n) begin
         case (r_state)
            RD_PRI: begin
               w_rdGnt = bus.rd_req;
               w_wrGnt = bus.wr_req & ~bus.rd_req;
            end
            WR_PRI: begin
               w_wrGnt = bus.wr_req;
               w_rdGnt = bus.rd_req & ~bus.wr_req;
            end
            FORCE: begin
               w_wrGnt = bus.wr_req;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_waitNext = r_waitCnt;
      if (!bus.wr_req || w_wrGnt)
         w_waitNext = 8'd0;
      else if (r_waitCnt < C_MAX_WAIT)
         w_waitNext = r_waitCnt + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RD_PRI;
         r_waitCnt  <= 8'd0;
         r_rdPend   <= 1'b0;
         r_rdValid  <= 1'b0;
         r_memEn    <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
      end else begin
         // Next state is a function of the sampled vblank and the new count.
         if (bus.vblank)
            r_state <= WR_PRI;
         else if (w_waitNext == C_MAX_WAIT)
            r_state <= FORCE;
         else
            r_state <= RD_PRI;
         r_waitCnt <= w_waitNext;
         r_memEn   <= w_rdGnt | w_wrGnt;
         r_memWe   <= w_wrGnt;
         if (w_wrGnt) begin
            r_memAddr  <= bus.wr_addr;
            r_memWdata <= bus.wr_data;
         end else if (w_rdGnt) begin
            r_memAddr  <= bus.rd_addr;
         end
         r_rdPend  <= w_rdGnt;
         r_rdValid <= r_rdPend;
      end
   end

   assign bus.rd_gnt    = w_rdGnt;
   assign bus.wr_gnt    = w_wrGnt;
   assign bus.wr_forced = w_wrGnt & (r_state == FORCE);
   assign bus.mem_en    = r_memEn;
   assign bus.mem_we    = r_memWe;
   assign bus.mem_addr  = r_memAddr;
   assign bus.mem_wdata = r_memWdata;
   assign bus.rd_valid  = r_rdValid;
   // Memory output is valid in the rd_valid cycle; zero it otherwise.
   assign bus.rd_data   = r_rdValid ? bus.mem_rdata : '0;
endmodule
`default_nettype wire

// File: tb/tb_scope_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_scope_fb_arbiter
//  Scoreboard bench: read expectations queued at grant, checked at rd_valid.
//  Rev 1.0
// ============================================================================
module tb_scope_fb_arbiter;
   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 8;
   localparam int MAX_WAIT = 4;

   typedef struct {
      logic [DATA_W-1:0] data;
      int                cyc;
   } sbEntry_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   nChecks = 0;
   int   nPass = 0;

   logic [DATA_W-1:0] mem    [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] refMem [0:(1<<ADDR_W)-1];
   sbEntry_t          sbQ [$];
   logic              expEn = 1'b0;
   logic              expWe = 1'b0;
   logic [ADDR_W-1:0] expAddr = '0;
   logic [DATA_W-1:0] expWdata = '0;

   scope_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   scope_fb_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Write-first single-port memory, one cycle read latency
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata     <= bus.mem_wdata;
         end else begin
            bus.mem_rdata <= mem[bus.mem_addr];
         end
      end
   end

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs === exp)
         nPass++;
      else
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Monitor: command stage, grant exclusivity and read scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         sbQ.delete();
         expEn = 1'b0;
         expWe = 1'b0;
      end else begin
         checkEq("memEn", {31'd0, bus.mem_en}, {31'd0, expEn});
         checkEq("memWe", {31'd0, bus.mem_we}, {31'd0, expWe});
         if (expEn) checkEq("memAddr", 32'(bus.mem_addr), 32'(expAddr));
         if (expWe) checkEq("memWdata", 32'(bus.mem_wdata), 32'(expWdata));
         checkEq("gntExcl", {31'd0, bus.rd_gnt & bus.wr_gnt}, 32'd0);
         if (bus.rd_valid) begin
            if (sbQ.size() == 0) begin
               checkEq("rdValidSpurious", {31'd0, bus.rd_valid}, 32'd0);
            end else begin
               sbEntry_t e;
               e = sbQ.pop_front();
               checkEq("rdData", 32'(bus.rd_data), 32'(e.data));
               checkEq("rdLatency", cyc, e.cyc);
            end
         end
         expEn = bus.rd_gnt | bus.wr_gnt;
         expWe = bus.wr_gnt;
         if (bus.wr_gnt) begin
            expAddr = bus.wr_addr;
            expWdata = bus.wr_data;
            refMem[bus.wr_addr] = bus.wr_data;
         end else if (bus.rd_gnt) begin
            sbEntry_t n;
            expAddr = bus.rd_addr;
            n.data = refMem[bus.rd_addr];
            n.cyc = cyc + 2;
            sbQ.push_back(n);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         mem[i] = '0;
         refMem[i] = '0;
      end
      mem[12'h010] = 8'hA1; refMem[12'h010] = 8'hA1;
      mem[12'h011] = 8'hB2; refMem[12'h011] = 8'hB2;
      mem[12'h012] = 8'hC3; refMem[12'h012] = 8'hC3;

      // Reset with both requests asserted
      rst_n = 1'b0;
      bus.vblank = 1'b0;
      bus.rd_req = 1'b1;
      bus.rd_addr = 12'h010;
      bus.wr_req = 1'b1;
      bus.wr_addr = 12'h000;
      bus.wr_data = 8'h00;
      repeat (3) tick();
      sample();
      checkEq("rstRdGnt", {31'd0, bus.rd_gnt}, 32'd0);
      checkEq("rstWrGnt", {31'd0, bus.wr_gnt}, 32'd0);
      checkEq("rstMemEn", {31'd0, bus.mem_en}, 32'd0);
      checkEq("rstMemWe", {31'd0, bus.mem_we}, 32'd0);
      checkEq("rstRdValid", {31'd0, bus.rd_valid}, 32'd0);
      checkEq("rstRdData", 32'(bus.rd_data), 32'd0);
      checkEq("rstWrForced", {31'd0, bus.wr_forced}, 32'd0);

      // Release; three back-to-back reads
      tick();
      bus.wr_req = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.rd_addr = 12'h010 + 12'(k);
         sample();
         checkEq("rdGntBurst", {31'd0, bus.rd_gnt}, 32'd1);
         tick();
      end
      bus.rd_req = 1'b0;
      repeat (4) tick();

      // Contention in active video: forced write every MAX_WAIT+1 cycles
      bus.rd_req = 1'b1;  bus.rd_addr = 12'h020;
      bus.wr_req = 1'b1;  bus.wr_addr = 12'h030;  bus.wr_data = 8'h77;
      for (int k = 0; k < 2 * (MAX_WAIT + 1); k++) begin
         sample();
         checkEq("contRdGnt", {31'd0, bus.rd_gnt}, {31'd0, (k % (MAX_WAIT + 1)) != MAX_WAIT});
         checkEq("contWrGnt", {31'd0, bus.wr_gnt}, {31'd0, (k % (MAX_WAIT + 1)) == MAX_WAIT});
         checkEq("contForced", {31'd0, bus.wr_forced}, {31'd0, (k % (MAX_WAIT + 1)) == MAX_WAIT});
         tick();
      end
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
      repeat (2) tick();

      // Vblank: priority switches the cycle after vblank rises
      bus.vblank = 1'b1;
      bus.rd_req = 1'b1;  bus.rd_addr = 12'h021;
      bus.wr_req = 1'b1;  bus.wr_addr = 12'h031;  bus.wr_data = 8'h88;
      sample();
      checkEq("vbEdgeRdGnt", {31'd0, bus.rd_gnt}, 32'd1);
      tick();
      for (int k = 0; k < 6; k++) begin
         sample();
         checkEq("vbWrGnt", {31'd0, bus.wr_gnt}, 32'd1);
         checkEq("vbRdGnt", {31'd0, bus.rd_gnt}, 32'd0);
         checkEq("vbForced", {31'd0, bus.wr_forced}, 32'd0);
         tick();
      end
      bus.wr_req = 1'b0;
      sample();
      checkEq("vbRdAlone", {31'd0, bus.rd_gnt}, 32'd1);
      checkEq("vbWrIdle", {31'd0, bus.wr_gnt}, 32'd0);
      tick();
      bus.rd_req = 1'b0;
      bus.vblank = 1'b0;
      repeat (3) tick();

      // Write then read same address on back-to-back grants
      bus.wr_req = 1'b1;  bus.wr_addr = 12'h100;  bus.wr_data = 8'h5A;
      sample();
      checkEq("cohWrGnt", {31'd0, bus.wr_gnt}, 32'd1);
      tick();
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b1;  bus.rd_addr = 12'h100;
      sample();
      checkEq("cohRdGnt", {31'd0, bus.rd_gnt}, 32'd1);
      tick();
      bus.rd_req = 1'b0;
      tick();
      sample();
      checkEq("cohRdValid", {31'd0, bus.rd_valid}, 32'd1);
      checkEq("cohRdData", 32'(bus.rd_data), 32'h5A);
      repeat (3) tick();

      // Reset one cycle after a read grant drops the read
      bus.rd_req = 1'b1;  bus.rd_addr = 12'h012;
      sample();
      checkEq("midRdGnt", {31'd0, bus.rd_gnt}, 32'd1);
      tick();
      bus.rd_req = 1'b0;
      rst_n = 1'b0;
      sample();
      checkEq("midMemEn", {31'd0, bus.mem_en}, 32'd0);
      checkEq("midRdValid", {31'd0, bus.rd_valid}, 32'd0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sample();
         checkEq("postRstRdValid", {31'd0, bus.rd_valid}, 32'd0);
         tick();
      end

      repeat (4) tick();
      checkEq("sbEmpty", sbQ.size(), 32'd0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
`default_nettype wire
